// File: rtl/dmem_mmio.sv
// dmem_mmio: data-memory stage for the single-cycle MIPS core.
// Word-addressed RAM below base B = 2**DM_AW - MMIO_WORDS, and an MMIO window
// from B upward:
//   B+0 GPIO_OUT, B+1 GPIO_IN, B+2 TMR_CTRL, B+3 TMR_CNT, B+4 TMR_CMP,
//   B+5 TMR_STAT, B+6 and B+7 reserved.
// Reads are combinational. Writes and state updates happen on the rising
// edge of clk.
// The compare timer is built only when DMEM_MMIO_TIMER_EN is defined.
// Otherwise its registers read as zero, writes to them are ignored and
// tmr_irq is held low.
module dmem_mmio #(
  parameter int N          = 32,
  parameter int DM_AW      = 8,
  parameter int GPIO_W     = 8,
  parameter int MMIO_WORDS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dm_we,
  input  logic              dm_re,
  input  logic [DM_AW-1:0]  dm_ad,
  input  logic [N-1:0]      dm_d,
  output logic [N-1:0]      dm_q,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              tmr_irq
);

  localparam int RAM_DEPTH = 2**DM_AW - MMIO_WORDS;

  localparam logic [DM_AW-1:0] A_GPIO_OUT = DM_AW'(RAM_DEPTH + 0);
  localparam logic [DM_AW-1:0] A_GPIO_IN  = DM_AW'(RAM_DEPTH + 1);
  localparam logic [DM_AW-1:0] A_TMR_CTRL = DM_AW'(RAM_DEPTH + 2);
  localparam logic [DM_AW-1:0] A_TMR_CNT  = DM_AW'(RAM_DEPTH + 3);
  localparam logic [DM_AW-1:0] A_TMR_CMP  = DM_AW'(RAM_DEPTH + 4);
  localparam logic [DM_AW-1:0] A_TMR_STAT = DM_AW'(RAM_DEPTH + 5);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic ram_sel;
  logic ram_we;
  logic wr_gpio;

  assign ram_sel = (dm_ad < A_GPIO_OUT);

  // A write that coincides with reset is dropped, including writes to RAM.
  assign ram_we  = dm_we & ram_sel & rst;
  assign wr_gpio = dm_we & (dm_ad == A_GPIO_OUT);

  // ---------------------------------------------------------------------
  // RAM: not reset, contents are undefined until written
  // ---------------------------------------------------------------------
  logic [N-1:0] ram_mem [RAM_DEPTH];

  // Store the write data into the addressed RAM word on the clock edge.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[dm_ad] <= dm_d;
    end
  end

  // ---------------------------------------------------------------------
  // GPIO: output register and 2-flop input synchronizer
  // ---------------------------------------------------------------------
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync2_q;

  // Next value of the GPIO output register: load on a CPU write, else hold.
  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_gpio) begin
      gpio_out_d = dm_d[GPIO_W-1:0];
    end
  end

  // Update the GPIO output and the synchronizer stages; all are cleared
  // asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= gpio_in;
      sync2_q    <= sync1_q;
    end
  end

  assign gpio_out = gpio_out_q;

  // ---------------------------------------------------------------------
  // Compare timer
  // ---------------------------------------------------------------------
  logic [N-1:0] tmr_ctrl_rd;
  logic [N-1:0] tmr_cnt_rd;
  logic [N-1:0] tmr_cmp_rd;
  logic [N-1:0] tmr_stat_rd;

`ifdef DMEM_MMIO_TIMER_EN
  logic [1:0]   ctrl_q, ctrl_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic [N-1:0] cmp_q, cmp_d;
  logic         match_q, match_d;
  logic         wr_ctrl, wr_cnt, wr_cmp, wr_stat;
  logic         tmr_en, tmr_auto, tmr_hit;

  assign wr_ctrl  = dm_we & (dm_ad == A_TMR_CTRL);
  assign wr_cnt   = dm_we & (dm_ad == A_TMR_CNT);
  assign wr_cmp   = dm_we & (dm_ad == A_TMR_CMP);
  assign wr_stat  = dm_we & (dm_ad == A_TMR_STAT);

  assign tmr_en   = ctrl_q[0];
  assign tmr_auto = ctrl_q[1];

  // A CPU load of CNT takes priority over the compare, so a match is only
  // raised on cycles where CNT is not being written. The compare uses the
  // pre-edge CMP value, which means a CMP write only counts from the next
  // cycle.
  assign tmr_hit  = tmr_en & (cnt_q == cmp_q) & ~wr_cnt;

  // Next state of the timer registers.
  always_comb begin
    ctrl_d  = ctrl_q;
    cmp_d   = cmp_q;
    cnt_d   = cnt_q;
    match_d = match_q;

    if (wr_ctrl) begin
      ctrl_d = dm_d[1:0];
    end
    if (wr_cmp) begin
      cmp_d = dm_d;
    end

    if (wr_cnt) begin
      cnt_d = dm_d;
    end else if (tmr_hit) begin
      cnt_d = tmr_auto ? '0 : cnt_q + 1'b1;
    end else if (tmr_en) begin
      cnt_d = cnt_q + 1'b1;
    end

    // When a hardware set and a software clear land in the same cycle,
    // the set wins.
    if (tmr_hit) begin
      match_d = 1'b1;
    end else if (wr_stat && dm_d[0]) begin
      match_d = 1'b0;
    end
  end

  // Timer state registers. Reset aborts a running count immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q  <= '0;
      cnt_q   <= '0;
      cmp_q   <= '1;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      match_q <= match_d;
    end
  end

  assign tmr_ctrl_rd = N'(ctrl_q);
  assign tmr_cnt_rd  = cnt_q;
  assign tmr_cmp_rd  = cmp_q;
  assign tmr_stat_rd = N'(match_q);
  assign tmr_irq     = match_q;
`else
  assign tmr_ctrl_rd = '0;
  assign tmr_cnt_rd  = '0;
  assign tmr_cmp_rd  = '0;
  assign tmr_stat_rd = '0;
  assign tmr_irq     = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Read data. It is combinational and zero when no read is requested.
  // ---------------------------------------------------------------------

  // Select the addressed word and zero-extend the narrow registers.
  always_comb begin
    dm_q = '0;
    if (dm_re) begin
      if (ram_sel) begin
        dm_q = ram_mem[dm_ad];
      end else begin
        case (dm_ad)
          A_GPIO_OUT: dm_q = N'(gpio_out_q);
          A_GPIO_IN:  dm_q = N'(sync2_q);
          A_TMR_CTRL: dm_q = tmr_ctrl_rd;
          A_TMR_CNT:  dm_q = tmr_cnt_rd;
          A_TMR_CMP:  dm_q = tmr_cmp_rd;
          A_TMR_STAT: dm_q = tmr_stat_rd;
          default:    dm_q = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// tb_dmem_mmio: directed, self-checking bench for dmem_mmio.
// Expected values go into a scoreboard queue when a step is driven. Each one
// is popped and compared when the DUT output is sampled, 1-2 time units after
// the rising edge.
// Timer expectations follow DMEM_MMIO_TIMER_EN, matching the RTL build.
module tb_dmem_mmio;
  localparam int N          = 32;
  localparam int DM_AW      = 8;
  localparam int GPIO_W     = 8;
  localparam int MMIO_WORDS = 8;
  localparam logic [7:0] B  = 8'd248;

  logic              clk;
  logic              rst;
  logic              dm_we;
  logic              dm_re;
  logic [DM_AW-1:0]  dm_ad;
  logic [N-1:0]      dm_d;
  logic [N-1:0]      dm_q;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              tmr_irq;

  dmem_mmio #(
    .N(N), .DM_AW(DM_AW), .GPIO_W(GPIO_W), .MMIO_WORDS(MMIO_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .dm_we(dm_we), .dm_re(dm_re), .dm_ad(dm_ad),
    .dm_d(dm_d), .dm_q(dm_q), .gpio_in(gpio_in), .gpio_out(gpio_out),
    .tmr_irq(tmr_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  // Pop the oldest expectation and compare it with the observed value.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, e);
      end
      $display("check %-12s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-cycle write.
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    dm_we = 1'b1; dm_ad = a; dm_d = d;
    tick();
    dm_we = 1'b0; dm_d = '0;
  endtask

  // Combinational read, compared against the expected word.
  task automatic rd(input logic [7:0] a, input logic [31:0] e, input string tag);
    dm_re = 1'b1; dm_ad = a;
    exp_q.push_back(e);
    #1;
    check(tag, dm_q);
    dm_re = 1'b0;
  endtask

  // Compare a directly observed pin.
  task automatic pin(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    check(tag, obs);
  endtask

  initial begin
    rst = 1'b0; dm_we = 1'b0; dm_re = 1'b0; dm_ad = '0; dm_d = '0; gpio_in = '0;
    repeat (2) tick();

    // Values held while reset is asserted.
    pin("rst_gpio", 32'(gpio_out), 32'h0);
    pin("rst_irq", 32'(tmr_irq), 32'h0);
    rd(B + 8'd1, 32'h0, "rst_gpin");
`ifdef DMEM_MMIO_TIMER_EN
    rd(B + 8'd4, 32'hFFFF_FFFF, "rst_cmp");
    rd(B + 8'd3, 32'h0, "rst_cnt");
    rd(B + 8'd2, 32'h0, "rst_ctrl");
`endif
    rst = 1'b1;
    tick();

    // RAM write followed by a read; no read strobe gives zero.
    wr(8'h10, 32'hDEAD_BEEF);
    rd(8'h10, 32'hDEAD_BEEF, "ram_rd");
    dm_ad = 8'h10; dm_re = 1'b0;
    exp_q.push_back(32'h0);
    #1 check("ram_re0", dm_q);

    // A simultaneous write and read shows the old value, then the new one.
    wr(8'h20, 32'h3);
    dm_we = 1'b1; dm_re = 1'b1; dm_ad = 8'h20; dm_d = 32'h5;
    exp_q.push_back(32'h3);
    #1 check("rdw_old", dm_q);
    tick();
    dm_we = 1'b0; dm_re = 1'b0;
    rd(8'h20, 32'h5, "rdw_new");
    rd(8'd247, 32'hxxxx_xxxx, "ram_unwr");
    wr(8'd247, 32'h1234_5678);
    rd(8'd247, 32'h1234_5678, "ram_last");

    // Reserved words read as zero and ignore writes.
    wr(B + 8'd6, 32'hFFFF_FFFF);
    rd(B + 8'd6, 32'h0, "resv6");
    rd(B + 8'd7, 32'h0, "resv7");

    // GPIO output register, including zero-extension on readback.
    wr(B, 32'hA5);
    pin("gpio_out", 32'(gpio_out), 32'hA5);
    rd(B, 32'hA5, "gpio_rd");
    wr(B, 32'hFFFF_FF5A);
    rd(B, 32'h5A, "gpio_zext");

    // GPIO input goes through two synchronizer stages.
    gpio_in = 8'h3C;
    rd(B + 8'd1, 32'h0, "gpin_e0");
    tick();
    rd(B + 8'd1, 32'h0, "gpin_e1");
    tick();
    rd(B + 8'd1, 32'h3C, "gpin_e2");

`ifdef DMEM_MMIO_TIMER_EN
    // Autoreload: CNT runs 0..4, then matches and reloads to 0.
    wr(B + 8'd4, 32'd4);
    wr(B + 8'd2, 32'h3);
    for (int k = 0; k < 5; k++) begin
      rd(B + 8'd3, 32'(k), "cnt_seq");
      pin("irq_low", 32'(tmr_irq), 32'h0);
      tick();
    end
    rd(B + 8'd3, 32'h0, "cnt_reload");
    pin("irq_set", 32'(tmr_irq), 32'h1);
    rd(B + 8'd5, 32'h1, "stat_rd");

    // A clear with no coincident match.
    wr(B + 8'd5, 32'h1);
    pin("irq_clr", 32'(tmr_irq), 32'h0);
    rd(B + 8'd3, 32'h1, "cnt_clr");

    // A clear in the same cycle as a match: the set wins.
    repeat (3) tick();
    rd(B + 8'd3, 32'h4, "cnt_at_cmp");
    wr(B + 8'd5, 32'h1);
    pin("irq_setwin", 32'(tmr_irq), 32'h1);
    rd(B + 8'd3, 32'h0, "cnt_setwin");

    // Writing STAT with bit0=0 has no effect.
    wr(B + 8'd5, 32'h0);
    pin("irq_w0", 32'(tmr_irq), 32'h1);
    wr(B + 8'd5, 32'h1);
    pin("irq_clr2", 32'(tmr_irq), 32'h0);

    // No autoreload. The new CMP value only applies from the next cycle.
    wr(B + 8'd2, 32'h1);
    rd(B + 8'd2, 32'h1, "ctrl_rd");
    rd(B + 8'd3, 32'h3, "cnt_pre_cmp");
    wr(B + 8'd4, 32'h3);
    rd(B + 8'd4, 32'h3, "cmp_rd");
    rd(B + 8'd3, 32'h4, "cnt_oldcmp");
    pin("irq_oldcmp", 32'(tmr_irq), 32'h0);

    // A CNT write on an increment cycle loads exactly the written value.
    wr(B + 8'd3, 32'h7);
    rd(B + 8'd3, 32'h7, "cnt_load");
    tick();
    rd(B + 8'd3, 32'h8, "cnt_inc");
    pin("irq_nomatch", 32'(tmr_irq), 32'h0);

    // Wrap from all-ones to zero, then match at 3 with no reload.
    wr(B + 8'd3, 32'hFFFF_FFFE);
    rd(B + 8'd3, 32'hFFFF_FFFE, "cnt_fe");
    tick();
    rd(B + 8'd3, 32'hFFFF_FFFF, "cnt_ff");
    tick();
    rd(B + 8'd3, 32'h0, "cnt_wrap");
    repeat (3) tick();
    rd(B + 8'd3, 32'h3, "cnt_3");
    pin("irq_pre3", 32'(tmr_irq), 32'h0);
    tick();
    rd(B + 8'd3, 32'h4, "cnt_noreload");
    pin("irq_wrapmatch", 32'(tmr_irq), 32'h1);

    // Reset mid-count clears the timer and GPIO without a clock edge.
    wr(B + 8'd3, 32'h2);
    rd(B + 8'd3, 32'h2, "cnt_mid");
    rst = 1'b0;
    #1;
    pin("arst_irq", 32'(tmr_irq), 32'h0);
    pin("arst_gpio", 32'(gpio_out), 32'h0);
    rd(B + 8'd3, 32'h0, "arst_cnt");
    rd(B + 8'd2, 32'h0, "arst_ctrl");
    rd(B + 8'd4, 32'hFFFF_FFFF, "arst_cmp");
`else
    // With the timer absent, its registers read zero and ignore writes.
    wr(B + 8'd4, 32'd4);
    wr(B + 8'd2, 32'h3);
    wr(B + 8'd3, 32'h7);
    wr(B + 8'd5, 32'h1);
    rd(B + 8'd2, 32'h0, "nt_ctrl");
    rd(B + 8'd3, 32'h0, "nt_cnt");
    rd(B + 8'd4, 32'h0, "nt_cmp");
    rd(B + 8'd5, 32'h0, "nt_stat");
    repeat (6) tick();
    pin("nt_irq", 32'(tmr_irq), 32'h0);

    // Reset clears GPIO without a clock edge.
    rst = 1'b0;
    #1;
    pin("arst_gpio", 32'(gpio_out), 32'h0);
    pin("arst_irq", 32'(tmr_irq), 32'h0);
`endif

    // A write that coincides with reset is lost, and RAM is not reset.
    dm_we = 1'b1; dm_ad = B; dm_d = 32'hFF;
    tick();
    dm_we = 1'b0;
    rst = 1'b1;
    tick();
    pin("rst_wrlost", 32'(gpio_out), 32'h0);
    rd(8'h10, 32'hDEAD_BEEF, "ram_keep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-memory stage directly downstream of the single-cycle MIPS core; consumes the core's dm_we, dm_re, dm_ad and dm_d, and returns dm_q in the same cycle.
- Contains a word-addressed RAM plus a top-of-map MMIO window: a GPIO output register, a synchronized GPIO input, and a compare timer with a sticky match flag/IRQ.
- Reads are combinational, as the single-cycle core requires; all writes and state updates occur on the rising clock edge.

Parameters:
- N, 32, data word width; matches core N.
- DM_AW, 8, word-address width; matches core dmAddB; map depth = 2**DM_AW.
- GPIO_W, 8, GPIO in/out width, max N.
- MMIO_WORDS, 8, number of top addresses reserved for MMIO; RAM depth = 2**DM_AW - MMIO_WORDS.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- dm_we  in  1  write strobe from core.
- dm_re  in  1  read strobe from core.
- dm_ad  in  DM_AW  word address.
- dm_d  in  N  write data (core Qt).
- dm_q  out  N  read data to core.
- gpio_in  in  GPIO_W  asynchronous external inputs.
- gpio_out  out  GPIO_W  GPIO output register.
- tmr_irq  out  1  level IRQ, equals the timer match flag.

Behaviour:
- Map (offsets from B = 2**DM_AW - MMIO_WORDS): B+0 GPIO_OUT (RW), B+1 GPIO_IN (RO), B+2 TMR_CTRL (RW; bit0 en, bit1 autoreload), B+3 TMR_CNT (RW), B+4 TMR_CMP (RW), B+5 TMR_STAT (bit0 match; write 1 to clear), B+6 and B+7 reserved (read 0, writes ignored).
- Addresses below B: RAM. Writes on the clk edge when dm_we=1. RAM is not reset; its contents are X until written.
- dm_q is combinational. When dm_re=0, dm_q=0. When dm_re=1, dm_q returns the selected word; narrow registers are zero-extended.
- dm_we=1 and dm_re=1 to the same address: dm_q shows the old value for that cycle; the new value is visible after the edge.
- Reset (rst=0, asynchronous): gpio_out=0, sync flops=0, TMR_CTRL=0, TMR_CNT=0, TMR_CMP=all-ones, match=0, tmr_irq=0. dm_q follows its read rule. Reset mid-operation aborts the timer immediately, and any coincident write is lost.
- GPIO_IN is synchronized through a 2-flop synchronizer. A gpio_in change becomes readable 2 edges later.
- Timer, per edge, in priority order:
  - A CPU write to TMR_CNT loads dm_d and suppresses the increment that cycle.
  - Otherwise, if en=1 and CNT==CMP: match<=1. CNT<=0 if autoreload=1, else CNT<=CNT+1 (wraps mod 2**N).
  - Otherwise, if en=1: CNT<=CNT+1.
  - If en=0: CNT holds.
- Match flag rules:
  - Write to TMR_STAT with dm_d[0]=1 clears match.
  - If a hardware set occurs in the same cycle as the clear, the set wins.
  - A write with dm_d[0]=0 has no effect.
- The CMP comparison uses CMP's pre-edge value. A write to CMP takes effect from the next cycle.
- No handshake or wait states: every access completes in one cycle. Out-of-range addresses cannot occur because dm_ad spans the full map.

Optional Feature:
- DMEM_MMIO_TIMER_EN defined: the timer (CTRL/CNT/CMP/STAT) is implemented as described.
- Not defined: no timer flops are synthesized. B+2..B+5 read 0, writes to them are ignored, and tmr_irq is tied to 0. GPIO and RAM are unchanged.

Test Plan:
- Reset, then write RAM[0x10]=0xDEADBEEF; next cycle, read with dm_re=1 -> dm_q=0xDEADBEEF. With dm_re=0 -> dm_q=0.
- Simultaneous write 0x5 and read at RAM[0x20] (old value 0x3) -> dm_q=0x3 that cycle, then 0x5 the following cycle.
- Write GPIO_OUT=0xA5 -> gpio_out=0xA5 after the edge. Set gpio_in=0x3C -> GPIO_IN reads 0x0 after 1 edge and 0x3C after 2 edges.
- CMP=4, CTRL=0b11 (en + autoreload) -> match and tmr_irq rise on the edge where CNT==4. CNT then sequences 0,1,2,3,4,0. Writing STAT=1 clears tmr_irq, unless CNT==CMP in that same cycle.
- CTRL=0b01, CMP=3, write CNT=7 -> CNT goes 7, 8, ... with no match until wrap (CNT=0xFFFFFFFF to 0, then 3). A write to CNT on an increment cycle loads the written value exactly.
- Assert rst mid-count (CNT=2) -> CNT=0, tmr_irq=0, gpio_out=0 immediately, without waiting for clk. Built without DMEM_MMIO_TIMER_EN: reading TMR_CNT -> 0 and tmr_irq stays 0.
